// File: rtl/rast_pkg.sv
// Shared rasterizer types, MSAA mode encodings and the sample step helper.
package rast_pkg;

   localparam int SIGFIG = 24;
   localparam int RADIX  = 10;
   localparam int VERTS  = 3;
   localparam int AXIS   = 3;
   localparam int COLORS = 3;

   localparam logic [3:0] SS_1X  = 4'b1000;
   localparam logic [3:0] SS_4X  = 4'b0100;
   localparam logic [3:0] SS_16X = 4'b0010;
   localparam logic [3:0] SS_64X = 4'b0001;

   typedef enum logic {WAIT_STATE, TEST_STATE} iter_state_t;

   typedef logic signed [SIGFIG-1:0] fix_t;

   typedef struct packed {
      fix_t x;
      fix_t y;
   } pt_t;

   // ll occupies the low half so the box reads as [0]=lower-left, [1]=upper-right.
   typedef struct packed {
      pt_t ur;
      pt_t ll;
   } box_t;

   typedef logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;
   typedef logic [COLORS-1:0][SIGFIG-1:0]          color_t;

   function automatic fix_t step_size(input logic [3:0] ss);
      fix_t s;
      case (ss)
         SS_4X:   s = fix_t'(1 << (RADIX-1));
         SS_16X:  s = fix_t'(1 << (RADIX-2));
         SS_64X:  s = fix_t'(1 << (RADIX-3));
         default: s = fix_t'(1 << RADIX);
      endcase
      return s;
   endfunction

endpackage

// File: rtl/sample_iterator_if.sv
// Bounding-box (R13) and sample-test (R14) side buses of the sample iterator.
interface iter_r13_if;
   import rast_pkg::*;

   tri_t       tri_R13S;
   color_t     color_R13U;
   box_t       box_R13S;
   logic       validTri_R13H;
   logic [3:0] subSample_RnnnnU;
   logic       halt_RnnnnL;

   modport master (
      output tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
      input  halt_RnnnnL
   );
   modport slave (
      input  tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU,
      output halt_RnnnnL
   );
endinterface

interface iter_r14_if;
   import rast_pkg::*;

   tri_t   tri_R14S;
   color_t color_R14U;
   pt_t    sample_R14S;
   logic   validSamp_R14H;

   modport master (output tri_R14S, color_R14U, sample_R14S, validSamp_R14H);
   modport slave  (input  tri_R14S, color_R14U, sample_R14S, validSamp_R14H);
endinterface

// File: rtl/iter_next_samp.sv
// Combinational raster step: next sample location (x fastest) and last-sample flag.
module iter_next_samp
   import rast_pkg::*;
(
   input  pt_t  samp_i,
   input  fix_t llx_i,
   input  pt_t  ur_i,
   input  fix_t step_i,
   output pt_t  nxt_o,
   output logic at_last_o
);

   always_comb begin
      nxt_o = samp_i;
      if (samp_i.x < ur_i.x) begin
         nxt_o.x = samp_i.x + step_i;
      end else if (samp_i.y < ur_i.y) begin
         nxt_o.x = llx_i;
         nxt_o.y = samp_i.y + step_i;
      end
   end

   assign at_last_o = (samp_i.x == ur_i.x) && (samp_i.y == ur_i.y);

endmodule

// File: rtl/sample_iterator.sv
// Raster-walks one triangle's box, one sample per cycle, first sample the cycle after accept.
// halt_RnnnnL holds upstream during traversal; ITER_PERF_EN adds triangle/sample counters.
module sample_iterator
   import rast_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   iter_r13_if.slave  r13,
   iter_r14_if.master r14
`ifdef ITER_PERF_EN
   ,
   output logic [31:0] triCount_RnnnnU,
   output logic [31:0] sampCount_RnnnnU
`endif
);

   iter_state_t state_q;
   tri_t        tri_q;
   color_t      color_q;
   fix_t        llx_q;
   pt_t         ur_q;
   fix_t        step_q;
   pt_t         samp_q;
   logic        vld_q;

   pt_t         samp_d;
   logic        at_last;
   logic        halt_l;
   logic        accept;

   iter_next_samp u_next (
      .samp_i    (samp_q),
      .llx_i     (llx_q),
      .ur_i      (ur_q),
      .step_i    (step_q),
      .nxt_o     (samp_d),
      .at_last_o (at_last)
   );

   // Opening the gate on the last sample lets the next triangle load with no bubble.
   assign halt_l = (state_q == WAIT_STATE) || at_last;
   assign accept = r13.validTri_R13H && halt_l;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= WAIT_STATE;
         vld_q   <= 1'b0;
         samp_q  <= '0;
         tri_q   <= '0;
         color_q <= '0;
         llx_q   <= '0;
         ur_q    <= '0;
         step_q  <= '0;
      end else if (accept) begin
         state_q <= TEST_STATE;
         vld_q   <= 1'b1;
         samp_q  <= r13.box_R13S.ll;
         tri_q   <= r13.tri_R13S;
         color_q <= r13.color_R13U;
         llx_q   <= r13.box_R13S.ll.x;
         ur_q    <= r13.box_R13S.ur;
         step_q  <= step_size(r13.subSample_RnnnnU);
      end else if (state_q == TEST_STATE) begin
         if (at_last) begin
            state_q <= WAIT_STATE;
            vld_q   <= 1'b0;
         end else begin
            samp_q  <= samp_d;
         end
      end
   end

   assign r13.halt_RnnnnL    = halt_l;
   assign r14.tri_R14S       = tri_q;
   assign r14.color_R14U     = color_q;
   assign r14.sample_R14S    = samp_q;
   assign r14.validSamp_R14H = vld_q;

`ifdef ITER_PERF_EN
   logic [31:0] tri_cnt_q;
   logic [31:0] samp_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tri_cnt_q  <= '0;
         samp_cnt_q <= '0;
      end else begin
         if (accept) tri_cnt_q  <= tri_cnt_q + 32'd1;
         if (vld_q)  samp_cnt_q <= samp_cnt_q + 32'd1;
      end
   end

   assign triCount_RnnnnU  = tri_cnt_q;
   assign sampCount_RnnnnU = samp_cnt_q;
`endif

   ll_le_ur_a: assert property (@(posedge clk) disable iff (rst)
      accept |-> (r13.box_R13S.ll.x <= r13.box_R13S.ur.x) &&
                 (r13.box_R13S.ll.y <= r13.box_R13S.ur.y));

endmodule

// File: tb/tb_sample_iterator.sv
// Directed bench for sample_iterator: traversal order, halt timing, back-to-back and reset abort.
module tb_sample_iterator;
   import rast_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   iter_r13_if u_r13 ();
   iter_r14_if u_r14 ();

`ifdef ITER_PERF_EN
   logic [31:0] tri_cnt;
   logic [31:0] samp_cnt;
`endif

   sample_iterator dut (
      .clk (clk),
      .rst (rst),
      .r13 (u_r13.slave),
      .r14 (u_r14.master)
`ifdef ITER_PERF_EN
      ,
      .triCount_RnnnnU  (tri_cnt),
      .sampCount_RnnnnU (samp_cnt)
`endif
   );

   always #5 clk = ~clk;

   localparam tri_t   TRI_A = {(VERTS*AXIS){24'h0000A5}};
   localparam tri_t   TRI_B = {(VERTS*AXIS){24'h00005A}};
   localparam color_t COL_A = {24'h000011, 24'h000022, 24'h000033};
   localparam color_t COL_B = {24'h0000AA, 24'h0000BB, 24'h0000CC};

   // Present a triangle, take it on the next edge, return #1 after that edge with valid dropped.
   task automatic send_tri(input tri_t t, input color_t c, input box_t b, input logic [3:0] ss);
      u_r13.tri_R13S         = t;
      u_r13.color_R13U       = c;
      u_r13.box_R13S         = b;
      u_r13.subSample_RnnnnU = ss;
      u_r13.validTri_R13H    = 1'b1;
      @(posedge clk); #1;
      u_r13.validTri_R13H    = 1'b0;
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #1;
      n_cmp++; if (u_r14.validSamp_R14H !== 1'b0) begin n_bad++;
         $display("FAIL reset_vld: got %b want 0", u_r14.validSamp_R14H); end
      n_cmp++; if (u_r13.halt_RnnnnL !== 1'b1) begin n_bad++;
         $display("FAIL reset_halt: got %b want 1", u_r13.halt_RnnnnL); end
      n_cmp++; if (u_r14.sample_R14S !== pt_t'(0)) begin n_bad++;
         $display("FAIL reset_sample: got %h want 0", u_r14.sample_R14S); end
      n_cmp++; if (u_r14.tri_R14S !== tri_t'(0) || u_r14.color_R14U !== color_t'(0)) begin n_bad++;
         $display("FAIL reset_tri_color: got %h / %h want 0", u_r14.tri_R14S, u_r14.color_R14U); end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_1x();
      pt_t  exp [6];
      box_t b;
      exp[0] = '{x: 0,    y: 0};
      exp[1] = '{x: 1024, y: 0};
      exp[2] = '{x: 2048, y: 0};
      exp[3] = '{x: 0,    y: 1024};
      exp[4] = '{x: 1024, y: 1024};
      exp[5] = '{x: 2048, y: 1024};
      b.ll = '{x: 0, y: 0};
      b.ur = '{x: 2048, y: 1024};
      send_tri(TRI_A, COL_A, b, SS_1X);
      u_r13.tri_R13S = TRI_B;
      n_cmp++; if (u_r14.tri_R14S !== TRI_A || u_r14.color_R14U !== COL_A) begin n_bad++;
         $display("FAIL 1x_latch: got %h / %h want %h / %h", u_r14.tri_R14S, u_r14.color_R14U, TRI_A, COL_A); end
      for (int i = 0; i < 6; i++) begin
         n_cmp++; if (u_r14.validSamp_R14H !== 1'b1 || u_r14.sample_R14S !== exp[i]) begin n_bad++;
            $display("FAIL 1x_samp[%0d]: got v=%b (%0d,%0d) want v=1 (%0d,%0d)", i, u_r14.validSamp_R14H,
                     u_r14.sample_R14S.x, u_r14.sample_R14S.y, exp[i].x, exp[i].y); end
         n_cmp++; if (u_r13.halt_RnnnnL !== (i == 5)) begin n_bad++;
            $display("FAIL 1x_halt[%0d]: got %b want %b", i, u_r13.halt_RnnnnL, (i == 5)); end
         @(posedge clk); #1;
      end
      n_cmp++; if (u_r14.validSamp_R14H !== 1'b0 || u_r13.halt_RnnnnL !== 1'b1) begin n_bad++;
         $display("FAIL 1x_done: got v=%b h=%b want v=0 h=1", u_r14.validSamp_R14H, u_r13.halt_RnnnnL); end
   endtask

   task automatic test_4x();
      pt_t  exp [4];
      box_t b;
      exp[0] = '{x: 1024, y: 1024};
      exp[1] = '{x: 1536, y: 1024};
      exp[2] = '{x: 1024, y: 1536};
      exp[3] = '{x: 1536, y: 1536};
      b.ll = '{x: 1024, y: 1024};
      b.ur = '{x: 1536, y: 1536};
      send_tri(TRI_B, COL_B, b, SS_4X);
      u_r13.subSample_RnnnnU = SS_1X;
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (u_r14.validSamp_R14H !== 1'b1 || u_r14.sample_R14S !== exp[i]) begin n_bad++;
            $display("FAIL 4x_samp[%0d]: got v=%b (%0d,%0d) want v=1 (%0d,%0d)", i, u_r14.validSamp_R14H,
                     u_r14.sample_R14S.x, u_r14.sample_R14S.y, exp[i].x, exp[i].y); end
         @(posedge clk); #1;
      end
      n_cmp++; if (u_r14.validSamp_R14H !== 1'b0) begin n_bad++;
         $display("FAIL 4x_done: got v=%b want 0", u_r14.validSamp_R14H); end
   endtask

   task automatic test_single();
      box_t b;
      pt_t  p;
      p = '{x: 3072, y: 0};
      b.ll = p;
      b.ur = p;
      n_cmp++; if (u_r13.halt_RnnnnL !== 1'b1) begin n_bad++;
         $display("FAIL single_halt_pre: got %b want 1", u_r13.halt_RnnnnL); end
      send_tri(TRI_A, COL_B, b, SS_64X);
      n_cmp++; if (u_r14.validSamp_R14H !== 1'b1 || u_r14.sample_R14S !== p) begin n_bad++;
         $display("FAIL single_samp: got v=%b (%0d,%0d) want v=1 (3072,0)", u_r14.validSamp_R14H,
                  u_r14.sample_R14S.x, u_r14.sample_R14S.y); end
      n_cmp++; if (u_r13.halt_RnnnnL !== 1'b1) begin n_bad++;
         $display("FAIL single_halt: got %b want 1", u_r13.halt_RnnnnL); end
      @(posedge clk); #1;
      n_cmp++; if (u_r14.validSamp_R14H !== 1'b0 || u_r13.halt_RnnnnL !== 1'b1) begin n_bad++;
         $display("FAIL single_done: got v=%b h=%b want v=0 h=1", u_r14.validSamp_R14H, u_r13.halt_RnnnnL); end
   endtask

   task automatic test_back_to_back();
      box_t   ba, bb;
      pt_t    exp_s [3];
      color_t exp_c [3];
      ba.ll = '{x: 0, y: 0};
      ba.ur = '{x: 1024, y: 0};
      bb.ll = '{x: 2048, y: 2048};
      bb.ur = '{x: 2048, y: 2048};
      exp_s[0] = '{x: 0, y: 0};
      exp_s[1] = '{x: 1024, y: 0};
      exp_s[2] = '{x: 2048, y: 2048};
      exp_c[0] = COL_A;
      exp_c[1] = COL_A;
      exp_c[2] = COL_B;
      send_tri(TRI_A, COL_A, ba, SS_1X);
      // Second triangle waits on the bus; it may only be taken on the last-sample edge.
      u_r13.tri_R13S      = TRI_B;
      u_r13.color_R13U    = COL_B;
      u_r13.box_R13S      = bb;
      u_r13.validTri_R13H = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if (u_r14.validSamp_R14H !== 1'b1 || u_r14.sample_R14S !== exp_s[i]) begin n_bad++;
            $display("FAIL b2b_samp[%0d]: got v=%b (%0d,%0d) want v=1 (%0d,%0d)", i, u_r14.validSamp_R14H,
                     u_r14.sample_R14S.x, u_r14.sample_R14S.y, exp_s[i].x, exp_s[i].y); end
         n_cmp++; if (u_r14.color_R14U !== exp_c[i]) begin n_bad++;
            $display("FAIL b2b_color[%0d]: got %h want %h", i, u_r14.color_R14U, exp_c[i]); end
         @(posedge clk); #1;
         if (i == 1) u_r13.validTri_R13H = 1'b0;
      end
      n_cmp++; if (u_r14.validSamp_R14H !== 1'b0) begin n_bad++;
         $display("FAIL b2b_done: got v=%b want 0", u_r14.validSamp_R14H); end
   endtask

   task automatic test_reset_mid();
      box_t b, b4;
      pt_t  first;
      int   nv;
      b.ll  = '{x: 0, y: 0};
      b.ur  = '{x: 2048, y: 2048};
      b4.ll = '{x: 1024, y: 1024};
      b4.ur = '{x: 1536, y: 1536};
      first = '{x: 1024, y: 1024};
      send_tri(TRI_A, COL_A, b, SS_1X);
      @(posedge clk); #1;
      n_cmp++; if (u_r14.validSamp_R14H !== 1'b1 || u_r14.sample_R14S !== pt_t'({24'sd1024, 24'sd0})) begin n_bad++;
         $display("FAIL mid_2nd: got v=%b (%0d,%0d) want v=1 (1024,0)", u_r14.validSamp_R14H,
                  u_r14.sample_R14S.x, u_r14.sample_R14S.y); end
      rst = 1'b1;
      #1;
      n_cmp++; if (u_r14.validSamp_R14H !== 1'b0 || u_r13.halt_RnnnnL !== 1'b1 || u_r14.sample_R14S !== pt_t'(0)) begin n_bad++;
         $display("FAIL mid_rst: got v=%b h=%b s=%h want v=0 h=1 s=0", u_r14.validSamp_R14H,
                  u_r13.halt_RnnnnL, u_r14.sample_R14S); end
`ifdef ITER_PERF_EN
      n_cmp++; if (samp_cnt !== 32'd0 || tri_cnt !== 32'd0) begin n_bad++;
         $display("FAIL perf_rst: got tri=%0d samp=%0d want 0 0", tri_cnt, samp_cnt); end
`endif
      rst = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if (u_r14.validSamp_R14H !== 1'b0) begin n_bad++;
         $display("FAIL mid_residual: got v=%b want 0", u_r14.validSamp_R14H); end
      send_tri(TRI_B, COL_B, b4, SS_4X);
      n_cmp++; if (u_r14.sample_R14S !== first) begin n_bad++;
         $display("FAIL mid_first: got (%0d,%0d) want (1024,1024)", u_r14.sample_R14S.x, u_r14.sample_R14S.y); end
      nv = 0;
      for (int i = 0; i < 6; i++) begin
         if (u_r14.validSamp_R14H === 1'b1) nv++;
         @(posedge clk); #1;
      end
      n_cmp++; if (nv !== 4) begin n_bad++;
         $display("FAIL mid_count: got %0d valid cycles want 4", nv); end
`ifdef ITER_PERF_EN
      n_cmp++; if (samp_cnt !== 32'd4 || tri_cnt !== 32'd1) begin n_bad++;
         $display("FAIL perf_count: got tri=%0d samp=%0d want 1 4", tri_cnt, samp_cnt); end
`endif
   endtask

   initial begin
      u_r13.tri_R13S         = '0;
      u_r13.color_R13U       = '0;
      u_r13.box_R13S         = '0;
      u_r13.validTri_R13H    = 1'b0;
      u_r13.subSample_RnnnnU = SS_1X;
      test_reset();
      test_1x();
      test_4x();
      test_single();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
